age_matrix_rs: RTL and testbench

Unified, non-banked reservation station, parametrised successor to the banked RS. Holds up to RS_SIZE renamed micro-ops and captures writeback wakeups on two source operands. Each cycle it issues up to ISSUE_WIDTH ready entries, oldest-first, using an age matrix. Sits between dispatch and a cluster of identical FUs. Frees an entry on the issue handshake.

---
 rtl/age_matrix_rs.sv | 246 ++++++++++++++++++++++++
 tb/tb_age_matrix_rs.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/age_matrix_rs.sv
// age_matrix_rs -- unified reservation station with two-source wakeup and multi-port select.
//
// Holds up to RS_SIZE renamed micro-ops. Writeback broadcasts wake matching source tags.
// Each cycle up to ISSUE_WIDTH eligible entries are presented. An entry is freed on the
// valid/ready handshake of its issue port.
//
// Build option: macro RS_OLDEST_FIRST_EN
//   defined   -> an age matrix is kept and each issue port takes the oldest remaining eligible
//                entry.
//   undefined -> no age matrix; port k takes the k-th lowest-index eligible entry.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i           synchronous flush: masks issue/dispatch this cycle, empties the RS
//   wr_*              WR_WIDTH dispatch ports (valid/ready, two source tags with used/ready
//                     flags, opaque payload)
//   wb_valid_i/pdest  WB_WIDTH wakeup broadcast ports
//   issue_*           ISSUE_WIDTH issue ports (valid/ready, payload)
//   free_cnt_o        free entries, registered state only
module age_matrix_rs #(
    parameter int unsigned RS_SIZE     = 8,
    parameter int unsigned WR_WIDTH    = 2,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned WB_WIDTH    = 4,
    parameter int unsigned PREG_NUM    = 64,
    parameter int unsigned PAYLOAD_W   = 64,
    parameter int unsigned PREG_W      = $clog2(PREG_NUM),
    parameter int unsigned CNT_W       = $clog2(RS_SIZE + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic [WR_WIDTH-1:0]              wr_valid_i,
    output logic [WR_WIDTH-1:0]              wr_ready_o,
    input  logic [WR_WIDTH*PREG_W-1:0]       wr_psrc0_i,
    input  logic [WR_WIDTH*PREG_W-1:0]       wr_psrc1_i,
    input  logic [WR_WIDTH-1:0]              wr_psrc0_valid_i,
    input  logic [WR_WIDTH-1:0]              wr_psrc1_valid_i,
    input  logic [WR_WIDTH-1:0]              wr_psrc0_ready_i,
    input  logic [WR_WIDTH-1:0]              wr_psrc1_ready_i,
    input  logic [WR_WIDTH*PAYLOAD_W-1:0]    wr_payload_i,
    input  logic [WB_WIDTH-1:0]              wb_valid_i,
    input  logic [WB_WIDTH*PREG_W-1:0]       wb_pdest_i,
    output logic [ISSUE_WIDTH-1:0]           issue_valid_o,
    input  logic [ISSUE_WIDTH-1:0]           issue_ready_i,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] issue_payload_o,
    output logic [CNT_W-1:0]                 free_cnt_o
);
    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   r_valid;
    logic [RS_SIZE-1:0]   r_s0_used;
    logic [RS_SIZE-1:0]   r_s0_rdy;
    logic [RS_SIZE-1:0]   r_s1_used;
    logic [RS_SIZE-1:0]   r_s1_rdy;
    logic [PREG_W-1:0]    r_s0_tag  [RS_SIZE];
    logic [PREG_W-1:0]    r_s1_tag  [RS_SIZE];
    logic [PAYLOAD_W-1:0] r_payload [RS_SIZE];

    logic [CNT_W-1:0]       w_free_cnt;
    logic [WR_WIDTH-1:0]    w_wr_ok;
    logic [RS_SIZE-1:0]     w_taken;
    logic [WR_WIDTH-1:0]    w_alloc_vld;
    logic [IDX_W-1:0]       w_alloc_idx [WR_WIDTH];
    logic [WR_WIDTH-1:0]    w_wr_s0_hit;
    logic [WR_WIDTH-1:0]    w_wr_s1_hit;
    logic [RS_SIZE-1:0]     w_s0_wake;
    logic [RS_SIZE-1:0]     w_s1_wake;
    logic [RS_SIZE-1:0]     w_elig;
    logic [RS_SIZE-1:0]     w_cand;
    logic [ISSUE_WIDTH-1:0] w_pick_vld;
    logic [IDX_W-1:0]       w_pick_idx [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] w_issue_fire;

    function automatic logic wb_hit(input logic [PREG_W-1:0]          tag,
                                    input logic [WB_WIDTH-1:0]        vld,
                                    input logic [WB_WIDTH*PREG_W-1:0] pdest);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < int'(WB_WIDTH); w++) begin
            if (vld[w] && (pdest[w*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Free count and dispatch ready: registered state only.
    always_comb begin
        w_free_cnt = CNT_W'(RS_SIZE);
        for (int e = 0; e < int'(RS_SIZE); e++) begin
            if (r_valid[e]) w_free_cnt = w_free_cnt - CNT_W'(1);
        end
    end

    assign free_cnt_o = w_free_cnt;

    always_comb begin
        w_wr_ok = '0;
        for (int i = 0; i < int'(WR_WIDTH); i++) begin
            w_wr_ok[i] = (w_free_cnt > CNT_W'(i));
        end
    end

    assign wr_ready_o = flush_i ? '0 : w_wr_ok;

    // Accepted ports take the lowest free entries in port order. Entries freed by this
    // cycle's issue are still marked valid here, so they are not reused until next cycle.
    always_comb begin
        w_taken     = '0;
        w_alloc_vld = '0;
        for (int p = 0; p < int'(WR_WIDTH); p++) begin
            w_alloc_idx[p] = '0;
            if (wr_valid_i[p] && wr_ready_o[p]) begin
                for (int e = 0; e < int'(RS_SIZE); e++) begin
                    if (!w_alloc_vld[p] && !r_valid[e] && !w_taken[e]) begin
                        w_alloc_vld[p] = 1'b1;
                        w_alloc_idx[p] = IDX_W'(e);
                        w_taken[e]     = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < int'(WR_WIDTH); p++) begin
            w_wr_s0_hit[p] = wb_hit(wr_psrc0_i[p*PREG_W +: PREG_W], wb_valid_i, wb_pdest_i);
            w_wr_s1_hit[p] = wb_hit(wr_psrc1_i[p*PREG_W +: PREG_W], wb_valid_i, wb_pdest_i);
        end
        for (int e = 0; e < int'(RS_SIZE); e++) begin
            w_s0_wake[e] = wb_hit(r_s0_tag[e], wb_valid_i, wb_pdest_i);
            w_s1_wake[e] = wb_hit(r_s1_tag[e], wb_valid_i, wb_pdest_i);
        end
    end

    assign w_elig = r_valid & (r_s0_rdy | ~r_s0_used) & (r_s1_rdy | ~r_s1_used);

`ifdef RS_OLDEST_FIRST_EN
    // r_age[i][j] = 1: entry i is older than entry j.
    logic [RS_SIZE-1:0] r_age   [RS_SIZE];
    logic [RS_SIZE-1:0] w_later [WR_WIDTH];
    logic [RS_SIZE-1:0] w_blk;

    // Entries written by higher-numbered ports this cycle are younger than port p's entry.
    always_comb begin
        logic [RS_SIZE-1:0] acc;
        acc = '0;
        for (int p = int'(WR_WIDTH) - 1; p >= 0; p--) begin
            w_later[p] = acc;
            if (w_alloc_vld[p]) acc[w_alloc_idx[p]] = 1'b1;
        end
    end

    // An entry wins when no other remaining candidate is older than it.
    always_comb begin
        w_cand     = w_elig;
        w_pick_vld = '0;
        w_blk      = '0;
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            w_pick_idx[k] = '0;
            for (int e = 0; e < int'(RS_SIZE); e++) begin
                w_blk    = w_cand & ~r_age[e];
                w_blk[e] = 1'b0;
                if (!w_pick_vld[k] && w_cand[e] && (w_blk == '0)) begin
                    w_pick_vld[k] = 1'b1;
                    w_pick_idx[k] = IDX_W'(e);
                    w_cand[e]     = 1'b0;
                end
            end
        end
    end

    // New entry: every other entry is older than it (column set), then its own row marks
    // only the same-cycle entries from later ports as younger.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int e = 0; e < int'(RS_SIZE); e++) r_age[e] <= '0;
        end else begin
            for (int p = 0; p < int'(WR_WIDTH); p++) begin
                if (w_alloc_vld[p]) begin
                    for (int j = 0; j < int'(RS_SIZE); j++) begin
                        if (j != int'(w_alloc_idx[p])) r_age[j][w_alloc_idx[p]] <= 1'b1;
                    end
                end
            end
            for (int p = 0; p < int'(WR_WIDTH); p++) begin
                if (w_alloc_vld[p]) r_age[w_alloc_idx[p]] <= w_later[p];
            end
        end
    end
`else
    // Position priority: each port takes the lowest-index remaining candidate.
    always_comb begin
        w_cand     = w_elig;
        w_pick_vld = '0;
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            w_pick_idx[k] = '0;
            for (int e = 0; e < int'(RS_SIZE); e++) begin
                if (!w_pick_vld[k] && w_cand[e]) begin
                    w_pick_vld[k] = 1'b1;
                    w_pick_idx[k] = IDX_W'(e);
                    w_cand[e]     = 1'b0;
                end
            end
        end
    end
`endif

    always_comb begin
        issue_valid_o   = '0;
        issue_payload_o = '0;
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            issue_valid_o[k]                          = w_pick_vld[k] && !flush_i;
            issue_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = r_payload[w_pick_idx[k]];
        end
    end

    assign w_issue_fire = issue_valid_o & issue_ready_i;

    // Wakeup may touch invalid entries; harmless since allocation overwrites the flags.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_valid <= '0;
        end else begin
            for (int e = 0; e < int'(RS_SIZE); e++) begin
                if (w_s0_wake[e]) r_s0_rdy[e] <= 1'b1;
                if (w_s1_wake[e]) r_s1_rdy[e] <= 1'b1;
            end
            for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
                if (w_issue_fire[k]) r_valid[w_pick_idx[k]] <= 1'b0;
            end
            for (int p = 0; p < int'(WR_WIDTH); p++) begin
                if (w_alloc_vld[p]) begin
                    r_valid[w_alloc_idx[p]]   <= 1'b1;
                    r_s0_tag[w_alloc_idx[p]]  <= wr_psrc0_i[p*PREG_W +: PREG_W];
                    r_s1_tag[w_alloc_idx[p]]  <= wr_psrc1_i[p*PREG_W +: PREG_W];
                    r_s0_used[w_alloc_idx[p]] <= wr_psrc0_valid_i[p];
                    r_s1_used[w_alloc_idx[p]] <= wr_psrc1_valid_i[p];
                    r_s0_rdy[w_alloc_idx[p]]  <= wr_psrc0_ready_i[p] | w_wr_s0_hit[p];
                    r_s1_rdy[w_alloc_idx[p]]  <= wr_psrc1_ready_i[p] | w_wr_s1_hit[p];
                    r_payload[w_alloc_idx[p]] <= wr_payload_i[p*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_age_matrix_rs.sv
module tb_age_matrix_rs;
    localparam int RS = 8;
    localparam int WR = 2;
    localparam int IS = 2;
    localparam int WB = 4;
    localparam int PW = 6;
    localparam int PL = 64;
    localparam int CW = $clog2(RS + 1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic [WR-1:0]     wr_valid;
    logic [WR-1:0]     wr_ready;
    logic [WR*PW-1:0]  wr_psrc0;
    logic [WR*PW-1:0]  wr_psrc1;
    logic [WR-1:0]     wr_psrc0_valid;
    logic [WR-1:0]     wr_psrc1_valid;
    logic [WR-1:0]     wr_psrc0_ready;
    logic [WR-1:0]     wr_psrc1_ready;
    logic [WR*PL-1:0]  wr_payload;
    logic [WB-1:0]     wb_valid;
    logic [WB*PW-1:0]  wb_pdest;
    logic [IS-1:0]     issue_valid;
    logic [IS-1:0]     issue_ready;
    logic [IS*PL-1:0]  issue_payload;
    logic [CW-1:0]     free_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    age_matrix_rs dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush),
        .wr_valid_i       (wr_valid),
        .wr_ready_o       (wr_ready),
        .wr_psrc0_i       (wr_psrc0),
        .wr_psrc1_i       (wr_psrc1),
        .wr_psrc0_valid_i (wr_psrc0_valid),
        .wr_psrc1_valid_i (wr_psrc1_valid),
        .wr_psrc0_ready_i (wr_psrc0_ready),
        .wr_psrc1_ready_i (wr_psrc1_ready),
        .wr_payload_i     (wr_payload),
        .wb_valid_i       (wb_valid),
        .wb_pdest_i       (wb_pdest),
        .issue_valid_o    (issue_valid),
        .issue_ready_i    (issue_ready),
        .issue_payload_o  (issue_payload),
        .free_cnt_o       (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entries with a dispatch sequence number as age.
    bit [RS-1:0]  m_valid, m_used0, m_rdy0, m_used1, m_rdy1;
    int           m_tag0 [RS];
    int           m_tag1 [RS];
    logic [PL-1:0] m_pay [RS];
    longint       m_seq  [RS];
    longint       seq_ctr = 0;

    int           e_free;
    bit [WR-1:0]  e_wrrdy;
    bit [IS-1:0]  e_ivld;
    int           e_pick [IS];

    function automatic bit tb_wb_hit(int tag);
        for (int w = 0; w < WB; w++) begin
            if (wb_valid[w] && int'(wb_pdest[w*PW +: PW]) == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_eval();
        bit [RS-1:0] taken;
        int best;
        e_free = RS;
        for (int e = 0; e < RS; e++) if (m_valid[e]) e_free--;
        for (int i = 0; i < WR; i++) e_wrrdy[i] = !flush && (e_free > i);
        taken = '0;
        for (int k = 0; k < IS; k++) begin
            best = -1;
            for (int e = 0; e < RS; e++) begin
                if (m_valid[e] && !taken[e] && (m_rdy0[e] || !m_used0[e]) &&
                    (m_rdy1[e] || !m_used1[e])) begin
`ifdef RS_OLDEST_FIRST_EN
                    if (best < 0 || m_seq[e] < m_seq[best]) best = e;
`else
                    if (best < 0) best = e;
`endif
                end
            end
            e_pick[k] = (best < 0) ? 0 : best;
            e_ivld[k] = (best >= 0) && !flush;
            if (best >= 0) taken[best] = 1'b1;
        end
    endtask

    task automatic model_commit();
        bit [RS-1:0] occ;
        int slot;
        if (rst || flush) begin
            m_valid = '0;
            return;
        end
        occ = m_valid;
        for (int e = 0; e < RS; e++) begin
            if (m_valid[e] && m_used0[e] && tb_wb_hit(m_tag0[e])) m_rdy0[e] = 1'b1;
            if (m_valid[e] && m_used1[e] && tb_wb_hit(m_tag1[e])) m_rdy1[e] = 1'b1;
        end
        for (int k = 0; k < IS; k++) if (e_ivld[k] && issue_ready[k]) m_valid[e_pick[k]] = 1'b0;
        for (int p = 0; p < WR; p++) begin
            if (wr_valid[p] && e_wrrdy[p]) begin
                slot = -1;
                for (int e = 0; e < RS; e++) if (slot < 0 && !occ[e]) slot = e;
                if (slot >= 0) begin
                    occ[slot]     = 1'b1;
                    m_valid[slot] = 1'b1;
                    m_tag0[slot]  = int'(wr_psrc0[p*PW +: PW]);
                    m_tag1[slot]  = int'(wr_psrc1[p*PW +: PW]);
                    m_used0[slot] = wr_psrc0_valid[p];
                    m_used1[slot] = wr_psrc1_valid[p];
                    m_rdy0[slot]  = wr_psrc0_ready[p] || tb_wb_hit(m_tag0[slot]);
                    m_rdy1[slot]  = wr_psrc1_ready[p] || tb_wb_hit(m_tag1[slot]);
                    m_pay[slot]   = wr_payload[p*PL +: PL];
                    m_seq[slot]   = seq_ctr;
                    seq_ctr++;
                end
            end
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0; wr_valid = '0; wr_psrc0 = '0; wr_psrc1 = '0;
        wr_psrc0_valid = '0; wr_psrc1_valid = '0; wr_psrc0_ready = '0; wr_psrc1_ready = '0;
        wr_payload = '0; wb_valid = '0; wb_pdest = '0; issue_ready = '0;
    endtask

    // One source (src0) op on port p; src1 unused.
    task automatic set_wr(int p, int tag0, bit rdy0, logic [PL-1:0] pay);
        wr_valid[p]        = 1'b1;
        wr_psrc0[p*PW +: PW] = PW'(tag0);
        wr_psrc0_valid[p]  = 1'b1;
        wr_psrc0_ready[p]  = rdy0;
        wr_psrc1_valid[p]  = 1'b0;
        wr_psrc1_ready[p]  = 1'b0;
        wr_payload[p*PL +: PL] = pay;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic clk_step();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        clk_step();
        clk_step();
        rst = 1'b0;
        settle();
        n_checks++;
        if (free_cnt !== CW'(8)) begin
            n_fail++; $display("FAIL reset_free: got %0d want 8", free_cnt);
        end
        n_checks++;
        if (wr_ready !== 2'b11) begin
            n_fail++; $display("FAIL reset_wrrdy: got %b want 11", wr_ready);
        end
        n_checks++;
        if (issue_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_ivld: got %b want 00", issue_valid);
        end
    endtask

    task automatic test_basic_issue();
        clear_inputs();
        set_wr(0, 1, 1'b1, 64'hA0);
        set_wr(1, 2, 1'b1, 64'hA1);
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (issue_valid !== 2'b11) begin
            n_fail++; $display("FAIL basic_ivld: got %b want 11", issue_valid);
        end
        n_checks++;
        if (issue_payload[63:0] !== 64'hA0 || issue_payload[127:64] !== 64'hA1) begin
            n_fail++; $display("FAIL basic_pay: got %h want a0/a1", issue_payload);
        end
        n_checks++;
        if (free_cnt !== CW'(6)) begin
            n_fail++; $display("FAIL basic_free6: got %0d want 6", free_cnt);
        end
        issue_ready = 2'b11;
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (free_cnt !== CW'(8) || issue_valid !== 2'b00) begin
            n_fail++; $display("FAIL basic_drain: got free %0d ivld %b want 8/00", free_cnt, issue_valid);
        end
    endtask

    task automatic test_fill_wakeup();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            set_wr(0, 5, 1'b0, 64'h100 + 64'(2 * c));
            set_wr(1, 5, 1'b0, 64'h101 + 64'(2 * c));
            clk_step();
        end
        clear_inputs();
        set_wr(0, 5, 1'b1, 64'hDEAD);
        settle();
        n_checks++;
        if (free_cnt !== CW'(0) || wr_ready !== 2'b00 || issue_valid !== 2'b00) begin
            n_fail++; $display("FAIL fill_full: got free %0d wrrdy %b ivld %b want 0/00/00",
                               free_cnt, wr_ready, issue_valid);
        end
        clk_step();
        clear_inputs();
        wb_valid = 4'b0100;
        wb_pdest[2*PW +: PW] = PW'(5);
        settle();
        n_checks++;
        if (issue_valid !== 2'b00) begin
            n_fail++; $display("FAIL fill_wake_same: got %b want 00", issue_valid);
        end
        clk_step();
        clear_inputs();
        issue_ready = 2'b11;
        settle();
        n_checks++;
        if (issue_valid !== 2'b11 || issue_payload[63:0] !== 64'h100 ||
            issue_payload[127:64] !== 64'h101) begin
            n_fail++; $display("FAIL fill_first: got %b %h want 11 100/101", issue_valid, issue_payload);
        end
        clk_step();
        settle();
        n_checks++;
        if (free_cnt !== CW'(2) || issue_payload[63:0] !== 64'h102 ||
            issue_payload[127:64] !== 64'h103) begin
            n_fail++; $display("FAIL fill_second: got free %0d pay %h want 2 102/103", free_cnt, issue_payload);
        end
        clk_step();
        clk_step();
        clk_step();
        settle();
        n_checks++;
        if (free_cnt !== CW'(8) || issue_valid !== 2'b00) begin
            n_fail++; $display("FAIL fill_drain: got free %0d ivld %b want 8/00", free_cnt, issue_valid);
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        set_wr(0, 7, 1'b0, 64'hB7);
        set_wr(1, 9, 1'b0, 64'hB9);
        wb_valid[0] = 1'b1;
        wb_pdest[0 +: PW] = PW'(7);
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (issue_valid !== 2'b01 || issue_payload[63:0] !== 64'hB7) begin
            n_fail++; $display("FAIL bypass: got %b %h want 01 b7", issue_valid, issue_payload[63:0]);
        end
        issue_ready = 2'b01;
        wb_valid[3] = 1'b1;
        wb_pdest[3*PW +: PW] = PW'(9);
        clk_step();
        clear_inputs();
        issue_ready = 2'b01;
        settle();
        n_checks++;
        if (issue_valid !== 2'b01 || issue_payload[63:0] !== 64'hB9) begin
            n_fail++; $display("FAIL wake_b9: got %b %h want 01 b9", issue_valid, issue_payload[63:0]);
        end
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (free_cnt !== CW'(8)) begin
            n_fail++; $display("FAIL bypass_drain: got %0d want 8", free_cnt);
        end
    endtask

    task automatic test_stall();
        logic [PL-1:0] exp0, exp1;
        clear_inputs();
        set_wr(0, 1, 1'b1, 64'h51);
        set_wr(1, 1, 1'b1, 64'h5A);
        clk_step();
        clear_inputs();
        issue_ready = 2'b01;
        clk_step();
        clear_inputs();
        set_wr(0, 1, 1'b1, 64'h5B);
        clk_step();
        clear_inputs();
        issue_ready = 2'b10;
        settle();
`ifdef RS_OLDEST_FIRST_EN
        exp0 = 64'h5A; exp1 = 64'h5B;
`else
        exp0 = 64'h5B; exp1 = 64'h5A;
`endif
        n_checks++;
        if (issue_valid !== 2'b11 || issue_payload[63:0] !== exp0 || issue_payload[127:64] !== exp1) begin
            n_fail++; $display("FAIL stall_pick: got %b %h want 11 %h/%h", issue_valid, issue_payload, exp0, exp1);
        end
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (issue_valid !== 2'b01 || issue_payload[63:0] !== exp0) begin
            n_fail++; $display("FAIL stall_held: got %b %h want 01 %h", issue_valid, issue_payload[63:0], exp0);
        end
        issue_ready = 2'b01;
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (free_cnt !== CW'(8)) begin
            n_fail++; $display("FAIL stall_drain: got %0d want 8", free_cnt);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        set_wr(0, 1, 1'b1, 64'h61);
        set_wr(1, 1, 1'b1, 64'h62);
        clk_step();
        clear_inputs();
        set_wr(0, 30, 1'b0, 64'h63);
        set_wr(1, 30, 1'b0, 64'h64);
        clk_step();
        clear_inputs();
        set_wr(0, 30, 1'b0, 64'h65);
        clk_step();
        clear_inputs();
        flush = 1'b1;
        issue_ready = 2'b11;
        set_wr(0, 1, 1'b1, 64'h66);
        set_wr(1, 1, 1'b1, 64'h67);
        settle();
        n_checks++;
        if (issue_valid !== 2'b00 || wr_ready !== 2'b00 || free_cnt !== CW'(3)) begin
            n_fail++; $display("FAIL flush_cycle: got ivld %b wrrdy %b free %0d want 00/00/3",
                               issue_valid, wr_ready, free_cnt);
        end
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (free_cnt !== CW'(8) || issue_valid !== 2'b00 || wr_ready !== 2'b11) begin
            n_fail++; $display("FAIL flush_after: got free %0d ivld %b wrrdy %b want 8/00/11",
                               free_cnt, issue_valid, wr_ready);
        end
        clear_inputs();
        set_wr(0, 1, 1'b1, 64'h71);
        set_wr(1, 1, 1'b1, 64'h72);
        clk_step();
        clear_inputs();
        rst = 1'b1;
        set_wr(0, 1, 1'b1, 64'h73);
        set_wr(1, 1, 1'b1, 64'h74);
        clk_step();
        clear_inputs();
        settle();
        n_checks++;
        if (free_cnt !== CW'(8) || issue_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid: got free %0d ivld %b want 8/00", free_cnt, issue_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            rst   = ($urandom_range(0, 79) == 0);
            flush = ($urandom_range(0, 29) == 0);
            for (int p = 0; p < WR; p++) begin
                wr_valid[p]            = 1'($urandom_range(0, 1));
                wr_psrc0[p*PW +: PW]   = PW'($urandom_range(0, 7));
                wr_psrc1[p*PW +: PW]   = PW'($urandom_range(0, 7));
                wr_psrc0_valid[p]      = 1'($urandom_range(0, 1));
                wr_psrc1_valid[p]      = 1'($urandom_range(0, 1));
                wr_psrc0_ready[p]      = ($urandom_range(0, 3) == 0);
                wr_psrc1_ready[p]      = ($urandom_range(0, 3) == 0);
                wr_payload[p*PL +: PL] = {$urandom, $urandom};
            end
            for (int w = 0; w < WB; w++) begin
                wb_valid[w]          = ($urandom_range(0, 3) == 0);
                wb_pdest[w*PW +: PW] = PW'($urandom_range(0, 7));
            end
            issue_ready = IS'($urandom_range(0, 3));
            settle();
            n_checks++;
            if (free_cnt !== CW'(e_free)) begin
                n_fail++; $display("FAIL rnd_free c%0d: got %0d want %0d", c, free_cnt, e_free);
            end
            n_checks++;
            if (wr_ready !== e_wrrdy) begin
                n_fail++; $display("FAIL rnd_wrrdy c%0d: got %b want %b", c, wr_ready, e_wrrdy);
            end
            n_checks++;
            if (issue_valid !== e_ivld) begin
                n_fail++; $display("FAIL rnd_ivld c%0d: got %b want %b", c, issue_valid, e_ivld);
            end
            for (int k = 0; k < IS; k++) begin
                if (e_ivld[k]) begin
                    n_checks++;
                    if (issue_payload[k*PL +: PL] !== m_pay[e_pick[k]]) begin
                        n_fail++; $display("FAIL rnd_pay c%0d p%0d: got %h want %h", c, k,
                                           issue_payload[k*PL +: PL], m_pay[e_pick[k]]);
                    end
                end
            end
            clk_step();
        end
    endtask

    initial begin
        m_valid = '0;
        test_reset();
        test_basic_issue();
        test_fill_wakeup();
        test_bypass();
        test_stall();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
